// File: rtl/fir_interp2.sv
// Interpolate-by-2 polyphase FIR: each accepted sample yields two outputs,
// one per phase, computed with a single multiply-accumulate per cycle.
module fir_interp2 #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 8,
  parameter int OUT_W = WIDTH + 4,
  parameter int SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     x_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        coef_wr,
  input  logic [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [WIDTH-1:0]     coef_data,
  output logic signed [OUT_W-1:0]     y_out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int AW    = $clog2(TAPS);
  localparam int HT    = TAPS / 2;
  localparam int DW    = $clog2(HT);
  localparam int ACC_W = 2 * WIDTH + AW;

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC0, MAC1, HOLD} state_t;

  state_t                   state;
  logic signed [WIDTH-1:0]  d [HT];
  logic signed [WIDTH-1:0]  h [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            cnt;
  logic                     phase;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  ysat;
  logic                     accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Phase p uses the even (p=0) or odd (p=1) coefficients against d[cnt].
  assign prod    = h[{cnt[DW-1:0], phase}] * d[cnt[DW-1:0]];
  assign shifted = acc >>> SHIFT;

  always_comb begin
    ysat = shifted[OUT_W-1:0];
    if (shifted > MAXV)
      ysat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shifted < MINV)
      ysat = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // The MAC states spend HT cycles accumulating, then one more to register y_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      phase     <= 1'b0;
      y_out     <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < HT; k++)
        d[k] <= '0;
      for (int i = 0; i < TAPS; i++)
        h[i] <= (i + 1 < TAPS - i) ? WIDTH'(i + 1) : WIDTH'(TAPS - i);
    end else begin
      case (state)
        IDLE: begin
          if (coef_wr)
            h[coef_addr] <= coef_data;
          if (accept) begin
            for (int k = HT - 1; k > 0; k--)
              d[k] <= d[k-1];
            d[0]  <= x_in;
            acc   <= '0;
            cnt   <= '0;
            phase <= 1'b0;
            state <= MAC0;
          end
        end
        MAC0, MAC1: begin
          if (cnt == AW'(HT)) begin
            y_out     <= ysat;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            acc <= acc + ACC_W'(prod);
            cnt <= cnt + AW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            if (!phase) begin
              phase <= 1'b1;
              state <= MAC1;
            end else begin
              phase <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: impulse, DC, backpressure, coefficient
// gating, saturation and mid-computation reset with hand-computed results.
module tb_fir_interp2;

  localparam int WIDTH = 16;
  localparam int TAPS  = 8;
  localparam int OUT_W = 20;
  localparam int LAT   = TAPS / 2 + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [WIDTH-1:0]  x_in;
  logic                     in_valid;
  logic                     in_ready;
  logic                     coef_wr;
  logic [2:0]               coef_addr;
  logic signed [WIDTH-1:0]  coef_data;
  logic signed [OUT_W-1:0]  y_out;
  logic                     out_valid;
  logic                     out_ready;

  int cmpCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  fir_interp2 #(.WIDTH(WIDTH), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic checkValue(input string tag, input logic signed [63:0] observed,
                            input logic signed [63:0] expected);
    cmpCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the sample is accepted on the following posedge.
  task automatic applyStimulus(input logic signed [WIDTH-1:0] x, input bit wr,
                               input logic [2:0] addr, input logic signed [WIDTH-1:0] data);
    checkValue("in_ready before accept", in_ready, 1);
    x_in = x; in_valid = 1'b1; coef_wr = wr; coef_addr = addr; coef_data = data;
    @(negedge clk);
    in_valid = 1'b0; coef_wr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int expected, input int expLat);
    int cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkValue({tag, " valid"}, out_valid, 1);
    checkValue({tag, " latency"}, cycles, expLat);
    checkValue({tag, " y_out"}, y_out, expected);
  endtask

  task automatic runPair(input string tag, input logic signed [WIDTH-1:0] x,
                         input int e0, input int e1);
    applyStimulus(x, 1'b0, 3'd0, '0);
    checkOutput({tag, " ph0"}, e0, LAT);
    @(negedge clk);
    checkOutput({tag, " ph1"}, e1, LAT);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; x_in = '0; in_valid = 1'b0; coef_wr = 1'b0;
    coef_addr = '0; coef_data = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkValue("reset out_valid", out_valid, 0);
    checkValue("reset y_out", y_out, 0);
    rst = 1'b0;
    checkValue("in_ready after release", in_ready, 1);

    runPair("imp0", 16'sd1, 1, 2);
    runPair("imp1", 16'sd0, 3, 4);
    runPair("imp2", 16'sd0, 4, 3);
    runPair("imp3", 16'sd0, 2, 1);
    runPair("imp4", 16'sd0, 0, 0);

    runPair("dc0", 16'sd100, 100, 200);
    runPair("dc1", 16'sd100, 400, 600);
    runPair("dc2", 16'sd100, 800, 900);
    runPair("dc3", 16'sd100, 1000, 1000);
    runPair("dc4", 16'sd100, 1000, 1000);
    runPair("dc5", 16'sd100, 1000, 1000);

    // Stalled consumer, with a stray sample offered that must not be taken.
    out_ready = 1'b0;
    applyStimulus(16'sd100, 1'b0, 3'd0, '0);
    checkOutput("bp ph0", 1000, LAT);
    x_in = 16'sd77; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkValue("bp held y_out", y_out, 1000);
      checkValue("bp held out_valid", out_valid, 1);
      checkValue("bp in_ready low", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp ph1", 1000, LAT);
    @(negedge clk);
    runPair("bp next", 16'sd0, 900, 800);

    // Writes during MAC0 are dropped; a write alongside acceptance applies.
    doReset();
    applyStimulus(16'sd0, 1'b0, 3'd0, '0);
    coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 16'sd9;
    @(negedge clk);
    coef_addr = 3'd1;
    @(negedge clk);
    coef_wr = 1'b0;
    checkOutput("cg0 ph0", 0, LAT - 2);
    @(negedge clk);
    checkOutput("cg0 ph1", 0, LAT);
    @(negedge clk);
    applyStimulus(16'sd1, 1'b1, 3'd0, 16'sd5);
    checkOutput("cg1 ph0", 5, LAT);
    @(negedge clk);
    checkOutput("cg1 ph1", 2, LAT);
    @(negedge clk);

    doReset();
    for (int i = 0; i < TAPS; i++) begin
      coef_wr = 1'b1; coef_addr = 3'(i); coef_data = 16'sd32767;
      @(negedge clk);
    end
    coef_wr = 1'b0;
    for (int i = 0; i < 4; i++)
      runPair("sat pos", 16'sd32767, 524287, 524287);
    runPair("sat neg0", -16'sd32768, 524287, 524287);
    runPair("sat neg1", -16'sd32768, -65534, -65534);
    runPair("sat neg2", -16'sd32768, -524288, -524288);
    runPair("sat neg3", -16'sd32768, -524288, -524288);

    // Reset while MAC0 is running must drop the pending result entirely.
    applyStimulus(16'sd1, 1'b0, 3'd0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkValue("midrst out_valid during", out_valid, 0);
    rst = 1'b0;
    checkValue("midrst in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkValue("midrst no output", out_valid, 0);
    end
    runPair("post0", 16'sd1, 1, 2);
    runPair("post1", 16'sd0, 3, 4);
    runPair("post2", 16'sd0, 4, 3);
    runPair("post3", 16'sd0, 2, 1);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
